uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  Serial-to-parallel receiver placed directly upstream of the 8-bit enabled capture register.
//  Samples an asynchronous UART line (8N1, LSB first) and recovers each byte.
//  Presents the byte on data_out with a one-cycle data_valid strobe.
//  data_out/data_valid wire straight to the register's d_in/en inputs.
// PARAMETERS
//  CLKS_PER_BIT  default 868  clk cycles per serial bit; legal range >= 4 (868 = 100 MHz / 115200)
//  DATA_W        default 8    payload bits per frame; fixed at 8 for this design
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  rx          in   1       asynchronous serial line, idle high
//  data_out    out  DATA_W  last correctly framed byte; holds between frames
//  data_valid  out  1       one-cycle strobe: data_out updated this cycle (drives downstream en)
//  frame_err   out  1       one-cycle strobe: stop bit sampled low, byte discarded
//  busy        out  1       high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - state=IDLE, bit counter=0, cycle counter=0, shift register=0
//   - synchronizer flops=1 (line idle)
//   - data_out=0, data_valid=0, frame_err=0, busy=0
//   - rst mid-frame aborts the frame with no strobe
//  Input path: rx passes through a 2-FF synchronizer (rx_s); FSM uses only rx_s.
//  Cycle counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0.
//  States:
//   IDLE:  cnt=0; rx_s==0 -> START
//   START: at cnt==CLKS_PER_BIT/2-1 (bit centre)
//          - rx_s==0 -> DATA, with cnt=0 and bit_idx=0
//          - rx_s==1 -> IDLE (glitch rejected, no strobe)
//   DATA:  at cnt==CLKS_PER_BIT-1
//          - shift <= {rx_s, shift[7:1]} (LSB first)
//          - bit_idx++
//          - after bit_idx 7 is sampled -> STOP with cnt=0
//   STOP:  at cnt==CLKS_PER_BIT-1, always return to IDLE
//          - rx_s==1: data_out<=shift, data_valid=1 for exactly one cycle
//          - rx_s==0: frame_err=1 for one cycle, data_out unchanged
//  Strobes: data_valid and frame_err are registered, mutually exclusive, and never high two cycles in a row.
//  Latency: strobe asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 (sync) + 1 cycles after the start-bit falling edge on rx.
//  Back-to-back frames: IDLE is entered at stop-bit centre, so a start edge arriving half a bit later is accepted.
//  No flow control: the downstream register always captures on en; nothing stalls the receiver.
//  Line held low (break): frame_err is raised; the FSM re-enters START at once and keeps flagging frame_err every frame time until the line returns high.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t
//   - localparam int UART_DATA_W = 8
//  Sub-module sync_2ff (1-bit, reset value parameter RST_VAL=1'b1), instantiated once for rx.
//  Main FSM, counters and output registers sit in uart_rx_byte: one always_ff plus one always_comb next-state block.
// TESTING  (CLKS_PER_BIT=4 in simulation)
//  1. Reset: hold rst 3 cycles with rx=1 -> data_out=8'h00, data_valid=0, frame_err=0, busy=0.
//  2. Single frame 8'hA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> one data_valid pulse with data_out=8'hA5, busy drops the same cycle.
//  3. Back-to-back 8'h00 then 8'hFF with no idle gap -> two data_valid pulses 40 cycles apart; data_out 8'h00 then 8'hFF.
//  4. Start glitch: rx low for 1 cycle only -> FSM returns to IDLE, no strobe, data_out unchanged.
//  5. Bad stop bit: frame 8'h3C with stop=0 -> frame_err pulse, data_valid stays 0, data_out keeps previous 8'hFF.
//  6. Reset mid-frame: assert rst during DATA bit 4 of 8'h55, then send 8'h81 -> no strobe for the aborted frame; next strobe carries data_out=8'h81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_DATA_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Capture the asynchronous input and re-time it through a second flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: recovers bytes LSB first and strobes data_valid or frame_err once per frame.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic              rx_s;
    rx_state_t         state_r;
    rx_state_t         state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [IDX_W-1:0]  bit_idx_r;
    logic [IDX_W-1:0]  bit_idx_nxt_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_nxt_s;
    logic [DATA_W-1:0] data_nxt_s;
    logic              valid_nxt_s;
    logic              ferr_nxt_s;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Next-state, counter, shifter and strobe decode for the frame FSM.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        data_nxt_s    = data_out;
        valid_nxt_s   = 1'b0;
        ferr_nxt_s    = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                if (!rx_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            // A start bit that is high again at its centre is treated as a glitch.
            START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_nxt_s     = '0;
                    bit_idx_nxt_s = '0;
                    if (!rx_s) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s     = '0;
                    shift_nxt_s   = {rx_s, shift_r[DATA_W-1:1]};
                    bit_idx_nxt_s = bit_idx_r + IDX_ONE;
                    if (bit_idx_r == IDX_LAST) begin
                        state_nxt_s = STOP;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            // Returning to IDLE at the stop-bit centre leaves half a bit to catch a back-to-back start.
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = IDLE;
                    if (rx_s) begin
                        data_nxt_s  = shift_r;
                        valid_nxt_s = 1'b1;
                    end else begin
                        ferr_nxt_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= '0;
            shift_r    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            shift_r    <= shift_nxt_s;
            data_out   <= data_nxt_s;
            data_valid <= valid_nxt_s;
            frame_err  <= ferr_nxt_s;
            busy       <= (state_nxt_s != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte with a scoreboard of expected strobes.
module tb_uart_rx_byte;

    localparam int CPB = 4;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    exp_t   exp_q[$];
    exp_t   mon_e;
    longint valid_cyc[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_mis = 0;
    logic   prev_strobe = 1'b0;
    logic   saw_busy;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Serialise one frame and queue the strobe it should produce.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        exp_t       e;
        bits     = {stop_bit, d, 1'b0};
        e.is_err = ~stop_bit;
        e.data   = stop_bit ? d : last_good;
        exp_q.push_back(e);
        if (stop_bit) last_good = d;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (data_valid || frame_err) begin
            check("strobe_excl", 32'(data_valid & frame_err), 32'd0);
            check("strobe_b2b", 32'(prev_strobe), 32'd0);
            check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", 32'(frame_err), 32'(mon_e.is_err));
                check("strobe_data", 32'(data_out), 32'(mon_e.data));
                check("busy_at_strobe", 32'(busy), 32'd0);
            end
            if (data_valid) valid_cyc.push_back(cyc);
        end
        prev_strobe = data_valid | frame_err;
    end

    initial begin
        // 1. Reset
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // 2. Single frame
        send_frame(8'hA5, 1'b1);
        wait_drain(20);
        check("t2_hold", 32'(data_out), 32'hA5);
        check("t2_valid_count", 32'(valid_cyc.size()), 32'd1);

        // 3. Back-to-back frames
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain(20);
        check("t3_valid_count", 32'(valid_cyc.size()), 32'd3);
        if (valid_cyc.size() >= 2)
            check("t3_gap", 32'(valid_cyc[valid_cyc.size()-1] - valid_cyc[valid_cyc.size()-2]), 32'd40);
        check("t3_data_out", 32'(data_out), 32'hFF);

        // 4. Start glitch
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
        end
        check("t4_busy_seen", 32'(saw_busy), 32'd1);
        repeat (2 * CPB) @(negedge clk);
        check("t4_busy_idle", 32'(busy), 32'd0);
        check("t4_data_out", 32'(data_out), 32'hFF);
        check("t4_valid_count", 32'(valid_cyc.size()), 32'd3);
        @(posedge clk);
        #1;

        // 5. Bad stop bit
        send_frame(8'h3C, 1'b0);
        rx = 1'b1;
        wait_drain(20);
        repeat (3 * CPB) @(negedge clk);
        check("t5_data_out", 32'(data_out), 32'hFF);
        check("t5_busy_idle", 32'(busy), 32'd0);
        check("t5_valid_count", 32'(valid_cyc.size()), 32'd3);
        @(posedge clk);
        #1;

        // 6. Reset in the middle of DATA bit 4
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h55, 1'b0};
            for (int i = 0; i < 5; i++) begin
                rx = bits[i];
                repeat (CPB) @(posedge clk);
                #1;
            end
            rx = bits[5];
            repeat (2) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_data", 32'(data_out), 32'h00);
        @(posedge clk);
        #1;
        send_frame(8'h81, 1'b1);
        wait_drain(20);
        check("t6_data_out", 32'(data_out), 32'h81);
        check("t6_valid_count", 32'(valid_cyc.size()), 32'd4);

        repeat (10) @(posedge clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
